// File: rtl/udma_extper_tx_arbiter_if.sv
// Channel-side and uDMA-side handshake bundle of the external-peripheral TX arbiter.
// master: the arbiter; slave: the surrounding peripherals and uDMA TX port.
interface udma_extper_tx_arbiter_if #(
  parameter int NB_CH = 4
);
  logic [NB_CH-1:0]   ch_req_i;
  logic [2*NB_CH-1:0] ch_datasize_i;
  logic [NB_CH-1:0]   ch_gnt_o;
  logic [NB_CH-1:0]   ch_valid_o;
  logic [NB_CH-1:0]   ch_ready_i;
  logic [31:0]        ch_data_o;
  logic               data_tx_req_o;
  logic               data_tx_gnt_i;
  logic [1:0]         data_tx_datasize_o;
  logic [31:0]        data_tx_i;
  logic               data_tx_valid_i;
  logic               data_tx_ready_o;

  modport master (
    input  ch_req_i, ch_datasize_i, ch_ready_i, data_tx_gnt_i, data_tx_i, data_tx_valid_i,
    output ch_gnt_o, ch_valid_o, ch_data_o, data_tx_req_o, data_tx_datasize_o, data_tx_ready_o
  );

  modport slave (
    output ch_req_i, ch_datasize_i, ch_ready_i, data_tx_gnt_i, data_tx_i, data_tx_valid_i,
    input  ch_gnt_o, ch_valid_o, ch_data_o, data_tx_req_o, data_tx_datasize_o, data_tx_ready_o
  );
endinterface

// File: rtl/udma_extper_tx_arbiter.sv
// Round-robin burst arbiter sharing one uDMA TX channel among NB_CH requesters.
// Optional macro UDMA_EXTPER_ARB_PRIO0_EN gives channel 0 absolute priority at arbitration.
module udma_extper_tx_arbiter #(
  parameter int NB_CH   = 4,
  parameter int BURST_W = 5,
  parameter int MAX_OUT = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [BURST_W-1:0]          cfg_burst_len_i,
  udma_extper_tx_arbiter_if.master    bus
);

  localparam int CH_W  = (NB_CH > 1) ? $clog2(NB_CH) : 1;
  localparam int OUT_W = $clog2(MAX_OUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CH_W-1:0]    r_rr_ptr;
  logic [CH_W-1:0]    r_sel;
  logic [BURST_W-1:0] r_issued;
  logic [BURST_W-1:0] r_len;
  logic [OUT_W-1:0]   r_out;
  logic [1:0]         r_datasize;

  logic [CH_W-1:0]    w_win_rr;
  logic [CH_W-1:0]    w_win;
  logic [CH_W-1:0]    w_idx;
  logic               w_found;
  logic               w_any_req;
  logic               w_sel_req;
  logic               w_out_nz;
  logic               w_req;
  logic               w_ready;
  logic               w_gnt_hs;
  logic               w_beat;
  logic [BURST_W-1:0] w_issued_nxt;
  logic [BURST_W-1:0] w_len_cfg;
  logic [CH_W-1:0]    w_sel_inc;
  logic [CH_W-1:0]    w_rr_nxt;
  logic [OUT_W-1:0]   w_out_nxt;

  assign w_any_req    = |bus.ch_req_i;
  assign w_sel_req    = bus.ch_req_i[r_sel];
  assign w_out_nz     = (r_out != {OUT_W{1'b0}});
  assign w_req        = (r_state == ST_BURST) & w_sel_req & (r_issued < r_len)
                        & (r_out < OUT_W'(MAX_OUT));
  assign w_ready      = (r_state != ST_IDLE) & bus.ch_ready_i[r_sel] & w_out_nz;
  assign w_gnt_hs     = w_req & bus.data_tx_gnt_i;
  assign w_beat       = bus.data_tx_valid_i & w_ready;
  assign w_issued_nxt = r_issued + {{(BURST_W-1){1'b0}}, w_gnt_hs};
  assign w_len_cfg    = (cfg_burst_len_i == {BURST_W{1'b0}}) ? BURST_W'(1) : cfg_burst_len_i;
  assign w_sel_inc    = (r_sel == CH_W'(NB_CH - 1)) ? {CH_W{1'b0}} : (r_sel + CH_W'(1));

  // First requester at or after the round-robin pointer, searched cyclically.
  always_comb begin
    w_win_rr = {CH_W{1'b0}};
    w_found  = 1'b0;
    w_idx    = {CH_W{1'b0}};
    for (int k = 0; k < NB_CH; k++) begin
      w_idx = CH_W'((int'(r_rr_ptr) + k) % NB_CH);
      if (!w_found && bus.ch_req_i[w_idx]) begin
        w_found  = 1'b1;
        w_win_rr = w_idx;
      end else begin
        w_found  = w_found;
      end
    end
  end

`ifdef UDMA_EXTPER_ARB_PRIO0_EN
  // Channel 0 preempts the rotation and does not advance the pointer.
  assign w_win    = bus.ch_req_i[0] ? {CH_W{1'b0}} : w_win_rr;
  assign w_rr_nxt = (r_sel == {CH_W{1'b0}}) ? r_rr_ptr : w_sel_inc;
`else
  assign w_win    = w_win_rr;
  assign w_rr_nxt = w_sel_inc;
`endif

  // Next state; the burst closes on the cycle its last word is granted.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) w_state_nxt = ST_BURST;
        else           w_state_nxt = ST_IDLE;
      end
      ST_BURST: begin
        if ((w_issued_nxt == r_len) || !w_sel_req) w_state_nxt = ST_DRAIN;
        else                                        w_state_nxt = ST_BURST;
      end
      ST_DRAIN: begin
        if (!w_out_nz) w_state_nxt = ST_IDLE;
        else           w_state_nxt = ST_DRAIN;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Outstanding words: a grant and a returned beat in the same cycle cancel.
  always_comb begin
    w_out_nxt = r_out;
    case ({w_gnt_hs, w_beat})
      2'b10:   w_out_nxt = r_out + OUT_W'(1);
      2'b01:   w_out_nxt = r_out - OUT_W'(1);
      default: w_out_nxt = r_out;
    endcase
  end

  // State, burst context and round-robin pointer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_rr_ptr   <= {CH_W{1'b0}};
      r_sel      <= {CH_W{1'b0}};
      r_issued   <= {BURST_W{1'b0}};
      r_len      <= {BURST_W{1'b0}};
      r_out      <= {OUT_W{1'b0}};
      r_datasize <= 2'b00;
    end else begin
      r_state <= w_state_nxt;
      r_out   <= w_out_nxt;
      if ((r_state == ST_IDLE) && w_any_req) begin
        r_sel      <= w_win;
        r_datasize <= bus.ch_datasize_i[{w_win, 1'b0} +: 2];
        r_len      <= w_len_cfg;
        r_issued   <= {BURST_W{1'b0}};
      end else if (r_state == ST_BURST) begin
        r_issued <= w_issued_nxt;
      end else begin
        r_issued <= r_issued;
      end
      if ((r_state == ST_DRAIN) && !w_out_nz) begin
        r_rr_ptr <= w_rr_nxt;
      end else begin
        r_rr_ptr <= r_rr_ptr;
      end
    end
  end

  assign bus.ch_gnt_o           = (r_state != ST_IDLE) ? (NB_CH'(1) << r_sel) : {NB_CH{1'b0}};
  assign bus.ch_valid_o         = (bus.data_tx_valid_i & w_out_nz) ? (NB_CH'(1) << r_sel)
                                                                    : {NB_CH{1'b0}};
  assign bus.ch_data_o          = bus.data_tx_i;
  assign bus.data_tx_req_o      = w_req;
  assign bus.data_tx_ready_o    = w_ready;
  assign bus.data_tx_datasize_o = r_datasize;

endmodule
